pb_event_decoder: RTL

//  Consumes the clean outputs of the push-button debouncer (status + press/release pulses).

---
 rtl/pb_event_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pb_event_decoder.sv
// Push-button gesture decoder: turns debounced press/release into short, long and double-click pulses.
// Optional auto-repeat while held long is enabled by defining PB_EVENT_REPEAT_EN.
module pb_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_WIDTH     = $clog2(
        ((LONG_CYCLES > DCLICK_CYCLES ? LONG_CYCLES : DCLICK_CYCLES) > REPEAT_CYCLES
            ? (LONG_CYCLES > DCLICK_CYCLES ? LONG_CYCLES : DCLICK_CYCLES)
            : REPEAT_CYCLES) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_status,
    input  logic pb_press,
    input  logic pb_release,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_WAIT2  = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DCLICK_LAST = CNT_WIDTH'(DCLICK_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_q, short_d;
    logic                 long_q, long_d;
    logic                 dbl_q, dbl_d;
    logic                 rep_d;
    logic                 busy_q;
    logic                 bothPulse;
    logic                 releaseEv;

    // Simultaneous press and release pulses are contradictory, so that cycle is frozen.
    assign bothPulse = pb_press & pb_release;
    // A dropped status level also ends a press, in case the release pulse was missed.
    assign releaseEv = pb_release | ~pb_status;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        rep_d   = 1'b0;
        if (!bothPulse) begin
            case (state_q)
                S_IDLE: begin
                    if (pb_press) state_d = S_PRESS1;
                end
                S_PRESS1: begin
                    if (releaseEv) begin
                        state_d = S_WAIT2;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = S_HOLD;
                        long_d  = 1'b1;
                    end
                end
                S_WAIT2: begin
                    if (pb_press) begin
                        state_d = S_PRESS2;
                    end else if (cnt_q == DCLICK_LAST) begin
                        state_d = S_IDLE;
                        short_d = 1'b1;
                    end
                end
                S_PRESS2: begin
                    if (releaseEv) begin
                        state_d = S_IDLE;
                        dbl_d   = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (releaseEv) begin
                        state_d = S_IDLE;
                    end
`ifdef PB_EVENT_REPEAT_EN
                    else if (cnt_q == CNT_WIDTH'(REPEAT_CYCLES - 1)) begin
                        rep_d = 1'b1;
                        cnt_d = '0;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef PB_EVENT_REPEAT_EN
    logic rep_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= 1'b0;
        else     rep_q <= rep_d;
    end

    assign repeat_pulse = rep_q;
`else
    logic unusedRep;
    assign unusedRep    = rep_d;
    assign repeat_pulse = 1'b0;
`endif

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;

endmodule
